// File: rtl/fetch_buffer_if.sv
// Fetch/dispatch bus for the instruction queue. The master side drives fetch and dispatch-ready;
// the slave side is the buffer.
interface fetch_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int WORD_W = 32
);
    logic                       fetch_valid;
    logic [WORD_W-1:0]          fetch_instr;
    logic [WORD_W-1:0]          fetch_pc;
    logic                       fetch_pred_taken;
    logic                       flush;
    logic                       dispatch_free;
    logic                       deq_ready;
    logic                       deq_valid;
    logic [WORD_W-1:0]          deq_instr;
    logic [WORD_W-1:0]          deq_pc;
    logic                       deq_pred_taken;
    logic [$clog2(DEPTH):0]     count;

    modport master (
        output fetch_valid, fetch_instr, fetch_pc, fetch_pred_taken, flush, deq_ready,
        input  dispatch_free, deq_valid, deq_instr, deq_pc, deq_pred_taken, count
    );

    modport slave (
        input  fetch_valid, fetch_instr, fetch_pc, fetch_pred_taken, flush, deq_ready,
        output dispatch_free, deq_valid, deq_instr, deq_pc, deq_pred_taken, count
    );
endinterface

// File: rtl/fetch_buffer.sv
// Circular instruction queue between fetch and dispatch. It holds up to DEPTH
// {instr, pc, pred} entries in program order and drops everything on flush.
module fetch_buffer #(
    parameter int DEPTH  = 4,
    parameter int WORD_W = 32
) (
    input  logic          CLK,
    input  logic          nRST,
    fetch_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WORD_W-1:0] instr_q [0:DEPTH-1];
    logic [WORD_W-1:0] pc_q    [0:DEPTH-1];
    logic              pred_q  [0:DEPTH-1];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic notEmpty;
    logic free;
    logic enq;
    logic deq;

    // Back-pressure comes only from registered occupancy, so fetch never sees a path from deq_ready.
    assign free     = (count_q != FULL);
    assign notEmpty = (count_q != '0);
    assign enq      = bus.fetch_valid && free && !bus.flush;
    assign deq      = notEmpty && bus.deq_ready && !bus.flush;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) tail_d = tail_q + PTR_W'(1);
            if (deq) head_d = head_q + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is never cleared; validity lives entirely in the pointers and count.
    always_ff @(posedge CLK) begin
        if (enq) begin
            instr_q[tail_q] <= bus.fetch_instr;
            pc_q[tail_q]    <= bus.fetch_pc;
            pred_q[tail_q]  <= bus.fetch_pred_taken;
        end
    end

    assign bus.dispatch_free  = free;
    assign bus.deq_valid      = notEmpty;
    assign bus.deq_instr      = notEmpty ? instr_q[head_q] : '0;
    assign bus.deq_pc         = notEmpty ? pc_q[head_q]    : '0;
    assign bus.deq_pred_taken = notEmpty ? pred_q[head_q]  : 1'b0;
    assign bus.count          = count_q;
endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: stimulus pushes accepted entries, a monitor
// pops and compares them whenever dispatch takes the head entry.
module tb_fetch_buffer;
    logic CLK = 1'b0;
    logic nRST;

    always #5 CLK = ~CLK;

    fetch_buffer_if #(.DEPTH(4), .WORD_W(32)) bus ();

    fetch_buffer #(.DEPTH(4), .WORD_W(32)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred;
    } entry_t;

    entry_t expQ[$];
    int testsRun    = 0;
    int testsFailed = 0;

    function automatic logic [31:0] instrOf(input logic [31:0] pc);
        return 32'h1300_0000 | pc;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs just after a rising edge, then waits out the edge that consumes them.
    task automatic applyStimulus(input logic fv, input logic [31:0] pc, input logic pred,
                                 input logic rdy, input logic fl, input logic rstN);
        entry_t e;
        nRST                 = rstN;
        bus.fetch_valid      = fv;
        bus.fetch_pc         = pc;
        bus.fetch_instr      = instrOf(pc);
        bus.fetch_pred_taken = pred;
        bus.deq_ready        = rdy;
        bus.flush            = fl;
        if (!rstN || fl) begin
            expQ.delete();
        end else if (fv && bus.dispatch_free) begin
            e.instr = instrOf(pc);
            e.pc    = pc;
            e.pred  = pred;
            expQ.push_back(e);
        end
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        entry_t e;
        if (nRST === 1'b1 && bus.deq_valid === 1'b1 && bus.deq_ready === 1'b1 && bus.flush === 1'b0) begin
            if (expQ.size() == 0) begin
                checkOutput("deq_unexpected", bus.deq_pc, 32'hFFFF_FFFF);
            end else begin
                e = expQ.pop_front();
                checkOutput("deq_pc", bus.deq_pc, e.pc);
                checkOutput("deq_instr", bus.deq_instr, e.instr);
                checkOutput("deq_pred", 32'(bus.deq_pred_taken), 32'(e.pred));
            end
        end
    end

    initial begin
        nRST                 = 1'b0;
        bus.fetch_valid      = 1'b0;
        bus.fetch_pc         = '0;
        bus.fetch_instr      = '0;
        bus.fetch_pred_taken = 1'b0;
        bus.deq_ready        = 1'b0;
        bus.flush            = 1'b0;

        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_count", 32'(bus.count), 32'd0);
        checkOutput("reset_free", 32'(bus.dispatch_free), 32'd1);
        checkOutput("reset_valid", 32'(bus.deq_valid), 32'd0);
        checkOutput("reset_pc", bus.deq_pc, 32'h0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0, 1'b1);
            checkOutput("fill_count", 32'(bus.count), 32'(i + 1));
        end
        checkOutput("full_free", 32'(bus.dispatch_free), 32'd0);
        checkOutput("full_head_pc", bus.deq_pc, 32'h0);

        applyStimulus(1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("full_deq_count", 32'(bus.count), 32'd3);
        checkOutput("full_deq_free", 32'(bus.dispatch_free), 32'd1);
        applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("retry_count", 32'(bus.count), 32'd4);

        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("drain_count", 32'(bus.count), 32'd0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 32'(i * 4), 1'(i % 2), 1'b1, 1'b0, 1'b1);
            checkOutput("stream_count", 32'(bus.count), 32'd1);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("stream_end_count", 32'(bus.count), 32'd0);

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'(32'h60 + i * 4), 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("preflush_count", 32'(bus.count), 32'd3);
        applyStimulus(1'b1, 32'h80, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("flush_count", 32'(bus.count), 32'd0);
        checkOutput("flush_valid", 32'(bus.deq_valid), 32'd0);
        checkOutput("flush_pc", bus.deq_pc, 32'h0);
        checkOutput("flush_instr", bus.deq_instr, 32'h0);
        checkOutput("flush_pred", 32'(bus.deq_pred_taken), 32'd0);
        checkOutput("flush_free", 32'(bus.dispatch_free), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("postflush_valid", 32'(bus.deq_valid), 32'd0);

        applyStimulus(1'b1, 32'h30, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h34, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("prereset_count", 32'(bus.count), 32'd2);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("midreset_count", 32'(bus.count), 32'd0);
        checkOutput("midreset_free", 32'(bus.dispatch_free), 32'd1);
        checkOutput("midreset_valid", 32'(bus.deq_valid), 32'd0);
        applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("after_reset_pc", bus.deq_pc, 32'h40);
        checkOutput("after_reset_pred", 32'(bus.deq_pred_taken), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
            checkOutput("empty_count", 32'(bus.count), 32'd0);
            checkOutput("empty_valid", 32'(bus.deq_valid), 32'd0);
        end
        applyStimulus(1'b1, 32'h50, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("empty_then_enq_pc", bus.deq_pc, 32'h50);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
